// File: rtl/lcd_cmd_sequencer.sv
// Purpose : queue host opcodes in a small FIFO and issue them one at a time to LCD_CTRL under its busy handshake.
// Latency : a command pushed into an empty FIFO with lcd_busy low strobes lcd_cmd_valid two cycles later.
// Backpr. : host_full is asserted at DEPTH entries; pushes while full are dropped and flagged as overflow.
module lcd_cmd_sequencer #(
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] host_cmd,
  input  logic       host_push,
  output logic       host_full,
  output logic [3:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  input  logic       lcd_busy,
  input  logic       lcd_done,
  output logic       seq_done,
  output logic [7:0] issued_cnt,
  output logic [2:0] err_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_FREE, DRAIN, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    lcd_cmd_q, lcd_cmd_d;
  logic          lcd_cmd_valid_q, lcd_cmd_valid_d;
  logic          seq_done_q, seq_done_d;
  logic [7:0]    issued_cnt_q, issued_cnt_d;
  logic [2:0]    err_q, err_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    mem_q [DEPTH];

  logic full;
  logic push_req;
  logic push_ok;
  logic pop;

  // Full is taken from the registered count, so a same-cycle pop never frees room for a push.
  assign full      = (count_q == CNT_FULL);
  assign push_req  = host_push && !seq_done_q;
  assign push_ok   = push_req && !full && (host_cmd <= 4'd11);
  assign pop       = (state_q == IDLE) && (count_q != '0) && !lcd_busy;

  assign host_full     = full;
  assign lcd_cmd       = lcd_cmd_q;
  assign lcd_cmd_valid = lcd_cmd_valid_q;
  assign seq_done      = seq_done_q;
  assign issued_cnt    = issued_cnt_q;
  assign err_flags     = err_q;

  // Next-state logic for the issue FSM, FIFO pointers and sticky status.
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    lcd_cmd_d       = lcd_cmd_q;
    lcd_cmd_valid_d = 1'b0;
    seq_done_d      = seq_done_q;
    issued_cnt_d    = issued_cnt_q;
    err_d           = err_q;
    wr_ptr_d        = wr_ptr_q + AW'(push_ok);
    rd_ptr_d        = rd_ptr_q + AW'(pop);
    count_d         = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);

    // Illegal opcodes and overflow are only flagged while the session is live.
    if (push_req && (host_cmd > 4'd11)) err_d[1] = 1'b1;
    if (push_req && full)               err_d[0] = 1'b1;

    case (state_q)
      IDLE: begin
        if (pop) begin
          lcd_cmd_d       = mem_q[rd_ptr_q];
          lcd_cmd_valid_d = 1'b1;
          if (issued_cnt_q != 8'hFF) issued_cnt_d = issued_cnt_q + 8'd1;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (lcd_busy) begin
          state_d = WAIT_FREE;
        end else if (timer_q == TMR_LAST) begin
          err_d[2] = 1'b1;
          state_d  = (lcd_cmd_q == 4'd0) ? DRAIN : IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_FREE: begin
        if (!lcd_busy) state_d = (lcd_cmd_q == 4'd0) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (lcd_done) begin
          seq_done_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        seq_done_d = 1'b1;
        count_d    = '0;
        rd_ptr_d   = wr_ptr_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and control registers; reset aborts the session and empties the queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      lcd_cmd_q       <= 4'd0;
      lcd_cmd_valid_q <= 1'b0;
      seq_done_q      <= 1'b0;
      issued_cnt_q    <= 8'd0;
      err_q           <= 3'd0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      lcd_cmd_q       <= lcd_cmd_d;
      lcd_cmd_valid_q <= lcd_cmd_valid_d;
      seq_done_q      <= seq_done_d;
      issued_cnt_q    <= issued_cnt_d;
      err_q           <= err_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  // FIFO storage; contents are don't-care outside the valid window so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= host_cmd;
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer: startup hold-off, ordered session, overflow,
// illegal opcode, acknowledge timeout and mid-session reset.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_lcd_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] host_cmd = 4'd0;
  logic       host_push = 1'b0;
  logic       host_full;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       lcd_busy = 1'b1;
  logic       lcd_done = 1'b0;
  logic       seq_done;
  logic [7:0] issued_cnt;
  logic [2:0] err_flags;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] sess_cmds [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

  lcd_cmd_sequencer #(.DEPTH(8), .ACK_TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .host_cmd      (host_cmd),
    .host_push     (host_push),
    .host_full     (host_full),
    .lcd_cmd       (lcd_cmd),
    .lcd_cmd_valid (lcd_cmd_valid),
    .lcd_busy      (lcd_busy),
    .lcd_done      (lcd_done),
    .seq_done      (seq_done),
    .issued_cnt    (issued_cnt),
    .err_flags     (err_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] c);
    host_cmd  = c;
    host_push = 1'b1;
    step();
    host_push = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Waits up to 20 cycles for a strobe; cyc is the number of edges it took.
  task automatic wait_strobe(output bit found, output logic [3:0] c, output int cyc);
    found = 1'b0;
    c     = 4'hx;
    cyc   = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      cyc++;
      if (lcd_cmd_valid) begin
        found = 1'b1;
        c     = lcd_cmd;
      end
    end
  endtask

  task automatic watch_no_strobe(input int n, output bit seen);
    seen = 1'b0;
    repeat (n) begin
      step();
      if (lcd_cmd_valid) seen = 1'b1;
    end
  endtask

  // Called in the ISSUE cycle: controller raises busy for n cycles, then drops it.
  task automatic ack(input int n);
    step();
    lcd_busy = 1'b1;
    repeat (n) step();
    lcd_busy = 1'b0;
    step();
  endtask

  initial begin
    bit         found;
    bit         seen;
    logic [3:0] c;
    int         cyc;

    // Reset state
    repeat (2) step();
    check("rst_valid", lcd_cmd_valid, 1'b0);
    check("rst_cmd", lcd_cmd, 4'd0);
    check("rst_full", host_full, 1'b0);
    check("rst_done", seq_done, 1'b0);
    check("rst_cnt", issued_cnt, 8'd0);
    check("rst_err", err_flags, 3'b000);
    reset = 1'b0;

    // Startup: busy held for 70 cycles, cmd 5 waits for it to fall
    lcd_busy = 1'b1;
    watch_no_strobe(30, seen);
    push(4'd5);
    watch_no_strobe(39, found);
    seen = seen | found;
    check("startup_no_strobe", seen, 1'b0);
    lcd_busy = 1'b0;
    wait_strobe(found, c, cyc);
    check("startup_found", found, 1'b1);
    check("startup_cyc", cyc, 1);
    check("startup_cmd", c, 4'd5);
    check("startup_cnt", issued_cnt, 8'd1);
    ack(1);

    // Full session 1,2,3,4,0 then write-back completion
    do_reset();
    lcd_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(sess_cmds[i]);
    lcd_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_strobe(found, c, cyc);
      check("sess_found", found, 1'b1);
      check("sess_cmd", c, sess_cmds[i]);
      ack((i == 4) ? 64 : 1);
    end
    check("sess_not_done_yet", seq_done, 1'b0);
    lcd_done = 1'b1;
    step();
    lcd_done = 1'b0;
    check("sess_done", seq_done, 1'b1);
    check("sess_cnt", issued_cnt, 8'd5);
    check("sess_err", err_flags, 3'b000);
    push(4'd3);
    watch_no_strobe(6, seen);
    check("post_done_no_strobe", seen, 1'b0);
    check("post_done_err", err_flags, 3'b000);
    check("post_done_sticky", seq_done, 1'b1);

    // Overflow: 9 pushes while controller is busy
    do_reset();
    lcd_busy = 1'b1;
    for (int i = 1; i <= 7; i++) push(4'(i));
    check("ovf_not_full7", host_full, 1'b0);
    push(4'd8);
    check("ovf_full8", host_full, 1'b1);
    check("ovf_err8", err_flags, 3'b000);
    push(4'd9);
    check("ovf_full9", host_full, 1'b1);
    check("ovf_err9", err_flags, 3'b001);

    // Illegal opcode 13, then boundary-legal opcode 11
    do_reset();
    lcd_busy = 1'b0;
    push(4'd13);
    watch_no_strobe(6, seen);
    check("illegal_no_strobe", seen, 1'b0);
    check("illegal_err", err_flags, 3'b010);
    check("illegal_full", host_full, 1'b0);
    push(4'd11);
    wait_strobe(found, c, cyc);
    check("cmd11_cyc", cyc, 1);
    check("cmd11_cmd", c, 4'd11);
    ack(1);

    // Acknowledge timeout on cmd 7, cmd 3 still issued afterwards
    lcd_busy = 1'b1;
    push(4'd7);
    push(4'd3);
    lcd_busy = 1'b0;
    wait_strobe(found, c, cyc);
    check("to_cmd7", c, 4'd7);
    repeat (4) step();
    check("to_err_before", err_flags, 3'b010);
    check("to_cmd_hold", lcd_cmd, 4'd7);
    check("to_valid_low", lcd_cmd_valid, 1'b0);
    step();
    check("to_err_after", err_flags, 3'b110);
    step();
    check("to_next_valid", lcd_cmd_valid, 1'b1);
    check("to_next_cmd", lcd_cmd, 4'd3);
    check("to_next_cnt", issued_cnt, 8'd3);

    // Reset in WAIT_FREE with three commands queued
    lcd_busy = 1'b1;
    push(4'd1);
    push(4'd2);
    push(4'd4);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", lcd_cmd_valid, 1'b0);
    check("mid_rst_cmd", lcd_cmd, 4'd0);
    check("mid_rst_full", host_full, 1'b0);
    check("mid_rst_done", seq_done, 1'b0);
    check("mid_rst_cnt", issued_cnt, 8'd0);
    check("mid_rst_err", err_flags, 3'b000);
    step();
    reset    = 1'b0;
    lcd_busy = 1'b0;
    watch_no_strobe(8, seen);
    check("mid_rst_fifo_lost", seen, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
